// File: rtl/xgriscv_fetch_queue.sv
//-----------------------------------------------------------------------------
// xgriscv_fetch_queue
//
// Instruction-fetch front end for the pipelined xgriscv core. Owns the fetch
// PC, reads instruction memory one word per cycle and buffers the fetched
// {pc, instr} pairs in a DEPTH-entry circular queue. The decode stage drains
// the queue through a valid/ready handshake. A redirect flushes the queue and
// restarts fetch at the new target.
//
// Optional feature: define XGRISCV_FETCHQ_STATS_EN to add two saturating
// 32-bit counters: stat_flush (redirect cycles) and stat_starve (cycles where
// decode was ready but nothing was valid).
//
// Ports:
//   clk          in   clock, rising-edge
//   reset        in   asynchronous active-low reset
//   imem_pc      out  fetch address to instruction memory
//   imem_instr   in   instruction at imem_pc, same-cycle return
//   redirect     in   flush queue, restart fetch at redirect_pc
//   redirect_pc  in   new fetch target
//   fetch_en     in   0 holds the fetch PC; pops still proceed
//   out_valid    out  head entry valid
//   out_ready    in   decode accepts head entry
//   out_pc       out  pc of head entry
//   out_instr    out  instruction of head entry
//   count        out  occupied entries
//   full         out  count == DEPTH
//   stat_flush   out  (stats build only) redirect-cycle counter
//   stat_starve  out  (stats build only) starved-decode counter
//-----------------------------------------------------------------------------
module xgriscv_fetch_queue #(
   parameter int          XLEN     = 32,
   parameter int          ILEN     = 32,
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PC_STEP  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [XLEN-1:0]          imem_pc,
   input  logic [ILEN-1:0]          imem_instr,
   input  logic                     redirect,
   input  logic [XLEN-1:0]          redirect_pc,
   input  logic                     fetch_en,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [ILEN-1:0]          out_instr,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
`ifdef XGRISCV_FETCHQ_STATS_EN
   ,
   output logic [31:0]              stat_flush,
   output logic [31:0]              stat_starve
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Saturating 32-bit increment used by the statistics counters.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [XLEN-1:0] mem_pc    [DEPTH];
   logic [ILEN-1:0] mem_instr [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   occ;

   logic pop;
   logic push;

   // Handshake and status decode.
   assign out_valid = (occ != '0);
   assign full      = (occ == CW'(DEPTH));
   assign pop       = out_valid & out_ready;
   // A pop frees the head slot in the same edge, so a full queue can still
   // accept a new word when decode is draining it.
   assign push      = fetch_en & ~redirect & (~full | pop);

   assign imem_pc   = fetch_pc;
   assign count     = occ;
   // Head is read straight from storage: no bypass from imem_instr, and the
   // value is stable while stalled because only a pop moves rd_ptr.
   assign out_pc    = mem_pc[rd_ptr];
   assign out_instr = mem_instr[rd_ptr];

   // Fetch PC, pointers and occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc <= XLEN'(RESET_PC);
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         occ      <= '0;
      end else if (redirect) begin
         // Redirect wins over everything, including a same-cycle pop.
         fetch_pc <= redirect_pc;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         occ      <= '0;
      end else begin
         if (push) begin
            fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            wr_ptr   <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            occ <= occ + CW'(1);
         end else if (pop && !push) begin
            occ <= occ - CW'(1);
         end
      end
   end

   // Queue storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc[i]    <= '0;
            mem_instr[i] <= '0;
         end
      end else if (push) begin
         mem_pc[wr_ptr]    <= fetch_pc;
         mem_instr[wr_ptr] <= imem_instr;
      end
   end

`ifdef XGRISCV_FETCHQ_STATS_EN
   // Statistics counters, independent of fetch_en.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_flush  <= '0;
         stat_starve <= '0;
      end else begin
         if (redirect) begin
            stat_flush <= sat_inc32(stat_flush);
         end
         if (!out_valid && out_ready) begin
            stat_starve <= sat_inc32(stat_starve);
         end
      end
   end
`endif

endmodule
